direct_mapped_cache: RTL and testbench

Direct-mapped, write-back, write-allocate data cache between the CPU request stage and main memory. It accepts one read or write request per cycle from the CPU on a 10-bit byte address and signals completion with `hit_miss`. The CPU advances to its next request on the clock edge where `hit_miss` = 1. On a miss, the cache writes back a dirty victim line and refills the line from memory over a 128-bit ready/request handshake.

---
 rtl/direct_mapped_cache.sv | 117 +++++++++++
 tb/tb_direct_mapped_cache.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/direct_mapped_cache.sv
// Direct-mapped, write-back, write-allocate data cache: 4 lines x 4 words, 10-bit byte address.
// Hits complete combinationally in IDLE; misses write back a dirty victim, then refill over a 128-bit handshake.
module direct_mapped_cache #(
  parameter int LINES = 4,
  parameter int WORDS = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         read_write,
  input  logic [9:0]   address,
  input  logic [31:0]  write_data,
  output logic         hit_miss,
  output logic [31:0]  Read_Data,
  output logic         mem_req,
  output logic         mem_we,
  output logic [9:0]   mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);

  localparam int LINE_BITS = WORDS * 32;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

  state_t               state;
  logic [LINES-1:0]     valid;
  logic [LINES-1:0]     dirty;
  logic [3:0]           tags  [LINES];
  logic [LINE_BITS-1:0] lines [LINES];

  logic [3:0]  tag_in;
  logic [1:0]  idx;
  logic [1:0]  word;
  logic [1:0]  byte_sel;
  logic [31:0] sel_word;
  logic [7:0]  sel_byte;
  logic        hit;

  assign tag_in   = address[9:6];
  assign idx      = address[5:4];
  assign word     = address[3:2];
  assign byte_sel = address[1:0];

  assign sel_word = lines[idx][{word, 5'b0} +: 32];
  assign sel_byte = sel_word[{byte_sel, 3'b0} +: 8];

  // The request is not latched: the CPU holds it stable until hit_miss.
  assign hit      = (state == IDLE) && !reset && valid[idx] && (tags[idx] == tag_in);
  assign hit_miss = hit;

  always_comb begin
    Read_Data = 32'b0;
    if (hit && !read_write) begin
      if (byte_sel == 2'b00) Read_Data = sel_word;
      else                   Read_Data = {24'b0, sel_byte};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      valid     <= '0;
      dirty     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            if (read_write) begin
              lines[idx][{word, 5'b0} +: 32] <= write_data;
              dirty[idx]                     <= 1'b1;
            end
          end else if (valid[idx] && dirty[idx]) begin
            state     <= WRITEBACK;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {tags[idx], idx, 4'b0};
            mem_wdata <= lines[idx];
          end else begin
            state     <= ALLOCATE;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= {tag_in, idx, 4'b0};
            mem_wdata <= '0;
          end
        end
        // Fetch is issued straight after the write-back so a dirty miss costs 2L+2 cycles.
        WRITEBACK: begin
          if (mem_ready) begin
            dirty[idx] <= 1'b0;
            state      <= ALLOCATE;
            mem_we     <= 1'b0;
            mem_addr   <= {tag_in, idx, 4'b0};
            mem_wdata  <= '0;
          end
        end
        ALLOCATE: begin
          if (mem_ready) begin
            lines[idx] <= mem_rdata;
            tags[idx]  <= tag_in;
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_direct_mapped_cache.sv
// Bench for direct_mapped_cache: directed scenarios plus random traffic against a flat-memory
// reference model and a latency-programmable memory responder.
module tb_direct_mapped_cache;

  logic         clock;
  logic         reset;
  logic         read_write;
  logic [9:0]   address;
  logic [31:0]  write_data;
  logic         hit_miss;
  logic [31:0]  Read_Data;
  logic         mem_req;
  logic         mem_we;
  logic [9:0]   mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  direct_mapped_cache dut (
    .clock      (clock),
    .reset      (reset),
    .read_write (read_write),
    .address    (address),
    .write_data (write_data),
    .hit_miss   (hit_miss),
    .Read_Data  (Read_Data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // arch: what the CPU should see for every word; mem: backing store; m*: which lines are cached.
  logic [31:0]  arch [256];
  logic [127:0] mem  [64];
  logic [3:0]   mtag [4];
  logic         mvalid [4];
  logic         mdirty [4];

  int checks;
  int errors;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] arch_line(input logic [5:0] ln);
    return {arch[{ln, 2'd3}], arch[{ln, 2'd2}], arch[{ln, 2'd1}], arch[{ln, 2'd0}]};
  endfunction

  function automatic logic [127:0] junk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
    end
    for (int i = 0; i < 256; i++) arch[i] = mem[i / 4][(i % 4) * 32 +: 32];
  endtask

  task automatic do_req(input logic rw, input logic [9:0] a, input logic [31:0] wd, input int lat);
    logic [1:0]   idx;
    logic         is_hit;
    logic         wb_pending;
    logic         done;
    logic         cap_we;
    logic [9:0]   cap_addr;
    logic [127:0] cap_wdata;
    logic [31:0]  w;
    logic [31:0]  exp_rd;
    int           exp_cyc;
    int           cyc;
    int           reqcnt;

    idx        = a[5:4];
    is_hit     = mvalid[idx] && (mtag[idx] == a[9:6]);
    wb_pending = !is_hit && mvalid[idx] && mdirty[idx];
    if (is_hit)          exp_cyc = 1;
    else if (wb_pending) exp_cyc = 2 * lat + 2;
    else                 exp_cyc = lat + 2;
    w = arch[a[9:2]];
    if (rw)                  exp_rd = 32'h0;
    else if (a[1:0] == 2'b0) exp_rd = w;
    else                     exp_rd = 32'((w >> (8 * int'(a[1:0]))) & 32'hFF);

    read_write = rw;
    address    = a;
    write_data = wd;
    cyc        = 0;
    reqcnt     = 0;
    done       = 1'b0;
    cap_we     = 1'b0;
    cap_addr   = '0;
    cap_wdata  = '0;

    while (!done && cyc < 60) begin
      @(negedge clock);
      cyc++;
      if (hit_miss) begin
        done = 1'b1;
        check("latency", 128'(cyc), 128'(exp_cyc));
        check("read_data", 128'(Read_Data), 128'(exp_rd));
        check("mem_req_at_hit", 128'(mem_req), 128'(0));
        mem_ready = 1'b0;
      end else begin
        check("read_data_wait", 128'(Read_Data), 128'(0));
        if (mem_req) begin
          reqcnt++;
          if (reqcnt == 1) begin
            cap_we    = mem_we;
            cap_addr  = mem_addr;
            cap_wdata = mem_wdata;
            check("mem_we", 128'(mem_we), 128'(wb_pending));
            if (wb_pending) begin
              check("wb_addr", 128'(mem_addr), 128'({mtag[idx], idx, 4'b0}));
              check("wb_data", mem_wdata, arch_line({mtag[idx], idx}));
            end else begin
              check("fetch_addr", 128'(mem_addr), 128'({a[9:6], idx, 4'b0}));
            end
          end else begin
            check("hold_we", 128'(mem_we), 128'(cap_we));
            check("hold_addr", 128'(mem_addr), 128'(cap_addr));
            check("hold_wdata", mem_wdata, cap_wdata);
          end
          if (reqcnt == lat) begin
            mem_ready = 1'b1;
            if (mem_we) begin
              mem[mem_addr[9:4]] = mem_wdata;
              wb_pending = 1'b0;
            end else begin
              mem_rdata = mem[mem_addr[9:4]];
            end
            reqcnt = 0;
          end else begin
            mem_ready = 1'b0;
            mem_rdata = junk();
          end
        end else begin
          // Stray ready pulses outside a request must be ignored.
          mem_ready = 1'($urandom_range(0, 1));
          mem_rdata = junk();
        end
      end
    end
    check("completed", 128'(done), 128'(1));
    @(posedge clock);
    #1;
    mem_ready = 1'b0;
    if (!is_hit) begin
      mtag[idx]   = a[9:6];
      mvalid[idx] = 1'b1;
      mdirty[idx] = 1'b0;
    end
    if (rw) begin
      arch[a[9:2]] = wd;
      mdirty[idx]  = 1'b1;
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    read_write = 1'b0;
    address    = '0;
    write_data = '0;
    mem_rdata  = '0;
    mem_ready  = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    for (int i = 0; i < 4; i++) mtag[i] = '0;
    model_reset();

    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    check("rst_hit_miss", 128'(hit_miss), 128'(0));
    check("rst_mem_req", 128'(mem_req), 128'(0));
    check("rst_mem_we", 128'(mem_we), 128'(0));
    check("rst_mem_addr", 128'(mem_addr), 128'(0));
    check("rst_mem_wdata", mem_wdata, 128'(0));
    check("rst_read_data", 128'(Read_Data), 128'(0));
    @(posedge clock);
    #1;
    reset = 1'b0;

    do_req(1'b1, 10'h1A8, 32'h3AB, 2);
    do_req(1'b0, 10'h1A8, 32'h0, 2);
    do_req(1'b1, 10'h1A8, 32'h3AC, 2);
    do_req(1'b0, 10'h1A8, 32'h0, 2);
    do_req(1'b0, 10'h108, 32'h0, 2);
    do_req(1'b0, 10'h128, 32'h0, 2);
    do_req(1'b0, 10'h1A8, 32'h0, 2);
    do_req(1'b1, 10'h1A8, 32'h3AD, 2);
    do_req(1'b1, 10'h168, 32'h3AE, 2);
    do_req(1'b0, 10'h168, 32'h0, 2);
    do_req(1'b0, 10'h1A8, 32'h0, 2);
    do_req(1'b0, 10'h1A9, 32'h0, 2);
    check("byte1_model", 128'(arch[8'h6A][15:8]), 128'(8'h03));

    // Reset while a fetch is outstanding.
    read_write = 1'b0;
    address    = 10'h2F0;
    write_data = '0;
    mem_ready  = 1'b0;
    @(negedge clock);
    check("abort_idle_req", 128'(mem_req), 128'(0));
    @(negedge clock);
    check("abort_req_up", 128'(mem_req), 128'(1));
    check("abort_fetch_addr", 128'(mem_addr), 128'(10'h2F0));
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("abort_req_down", 128'(mem_req), 128'(0));
    check("abort_hit_miss", 128'(hit_miss), 128'(0));
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_reset();
    do_req(1'b0, 10'h2F0, 32'h0, 2);

    // Dirty-miss latency sweep.
    do_req(1'b1, 10'h014, 32'hCAFE_0001, 1);
    do_req(1'b0, 10'h054, 32'h0, 1);
    do_req(1'b1, 10'h018, 32'hCAFE_0005, 5);
    do_req(1'b0, 10'h098, 32'h0, 5);
    do_req(1'b0, 10'h018, 32'h0, 5);

    for (int n = 0; n < 150; n++) begin
      logic [9:0] ra;
      ra = {2'($urandom_range(0, 1)) ^ 2'b10, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63))};
      do_req(1'($urandom_range(0, 1)), ra, $urandom, int'($urandom_range(1, 4)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
